// File: rtl/grf_pkg.sv
// grf_pkg: shared defaults, address-width helper and the write-trace format
// for the multi-port general register file.
package grf_pkg;

    localparam int unsigned GRF_DATA_W = 32;
    localparam int unsigned GRF_NREG   = 32;

    // time@pc: $reg <= data  (pc in hex, reg in decimal, data in hex)
    localparam string GRF_TRACE_FMT = "%0t@%h: $%0d <= %h";

    // Address width for a register count; never narrower than one bit.
    function automatic int unsigned grf_aw(input int unsigned nreg);
        return (nreg <= 1) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register pending bits for in-flight producers.
//   clk, reset            clock, async active-high reset (clears all pending bits)
//   we0/wa0, we1/wa1      write ports; a committed write clears pending[wa]
//   iss_valid, iss_addr   issuing producer; sets pending[iss_addr] (set beats clear)
//   rd_addr               NRD packed read addresses
//   rd_busy               per read port: pending and not being written this cycle
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter  int unsigned NREG = GRF_NREG,
    parameter  int unsigned NRD  = 2,
    localparam int unsigned AW   = grf_aw(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;
    logic [AW-1:0]   w_ra;

    function automatic logic valid_dst(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < int'(NREG));
    endfunction

    // Clears first, then the set, so a same-cycle issue to the written
    // register leaves it pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (we0 && valid_dst(wa0))
            w_pending_nxt[wa0] = 1'b0;
        if (we1 && valid_dst(wa1))
            w_pending_nxt[wa1] = 1'b0;
        if (iss_valid && valid_dst(iss_addr))
            w_pending_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pending <= '0;
        else
            r_pending <= w_pending_nxt;
    end

    always_comb begin
        rd_busy = '0;
        w_ra    = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            w_ra = rd_addr[i*AW +: AW];
            if (!reset && valid_dst(w_ra))
                rd_busy[i] = r_pending[w_ra]
                             && !(we0 && wa0 == w_ra)
                             && !(we1 && wa1 == w_ra);
        end
    end

endmodule

// File: rtl/grf_multiport.sv
// grf_multiport: NRD-read / 2-write register file, register 0 hardwired zero.
//   clk, reset          clock, async active-high reset (clears registers and scoreboard)
//   rd_addr / rd_data   NRD packed combinational read ports with same-cycle write bypass
//   rd_busy             per read port: register has an outstanding producer
//   we*/wa*/wd*         write ports; port 1 wins a same-address collision
//   wpc0, wpc1          PC of the writing instruction, used only by the write trace
//   iss_valid/iss_addr  destination of an issuing producer (scoreboard set)
module grf_multiport
    import grf_pkg::*;
#(
    parameter  int unsigned DATA_W = GRF_DATA_W,
    parameter  int unsigned NREG   = GRF_NREG,
    parameter  int unsigned NRD    = 2,
    parameter  bit          TRACE  = 1'b1,
    localparam int unsigned AW     = grf_aw(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa0,
    input  logic [AW-1:0]         wa1,
    input  logic [DATA_W-1:0]     wd0,
    input  logic [DATA_W-1:0]     wd1,
    input  logic [31:0]           wpc0,
    input  logic [31:0]           wpc1,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_addr
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [AW-1:0]     w_ra;

    function automatic logic valid_dst(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < int'(NREG));
    endfunction

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            if (we0 && valid_dst(wa0))
                r_regs[wa0] <= wd0;
            if (we1 && valid_dst(wa1))
                r_regs[wa1] <= wd1;
        end
    end

    always_comb begin
        rd_data = '0;
        w_ra    = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            w_ra = rd_addr[i*AW +: AW];
            if (!reset && valid_dst(w_ra)) begin
                if (we1 && wa1 == w_ra)
                    rd_data[i*DATA_W +: DATA_W] = wd1;
                else if (we0 && wa0 == w_ra)
                    rd_data[i*DATA_W +: DATA_W] = wd0;
                else
                    rd_data[i*DATA_W +: DATA_W] = r_regs[w_ra];
            end
        end
    end

    grf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we0       (we0),
        .wa0       (wa0),
        .we1       (we1),
        .wa1       (wa1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

    // Simulation-only write trace; register-0 writes are printed too, and a
    // collided port-0 write is suppressed because it never commits.
    if (TRACE) begin : g_trace
`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (!reset) begin
                if (we0 && !(we1 && wa1 == wa0 && wa0 != '0))
                    $display("%s", $sformatf(GRF_TRACE_FMT, $time, wpc0 - 32'd4, wa0, wd0));
                if (we1)
                    $display("%s", $sformatf(GRF_TRACE_FMT, $time, wpc1 - 32'd4, wa1, wd1));
            end
        end
`endif
    end

endmodule

// File: doc/grf_multiport.md
# grf_multiport

Parametrised general register file for the pipelined MIPS core, successor to the single-write, two-read GRF in decode. Provides NRD combinational read ports and two write ports with a fixed collision priority. Same-cycle write-to-read bypass removes the separate decode-stage forwarding mux. A per-register pending scoreboard lets the hazard unit stall on in-flight producers.

## Interface
- DATA_W, 32, register width
- NREG, 32, register count; address width AW = clog2(NREG); register 0 is hardwired zero
- NRD, 2, number of read ports (1..4)
- TRACE, 1, when 1, emit a simulation write trace line per accepted write
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all registers and the scoreboard
- rd_addr  in  NRD*AW  read addresses, port i in slice i
- rd_data  out  NRD*DATA_W  read data, port i in slice i
- rd_busy  out  NRD  port i's register has an outstanding producer not being written this cycle
- we0, we1  in  1 each  write enables
- wa0, wa1  in  AW each  write addresses
- wd0, wd1  in  DATA_W each  write data
- wpc0, wpc1  in  32 each  PC of the writing instruction, trace only
- iss_valid  in  1  an instruction that will write a register issues this cycle
- iss_addr  in  AW  destination of the issuing instruction

## Operation
- Reset: asynchronous, active-high. While asserted, all registers = 0, all pending bits = 0, and bypass is disabled. rd_data reads 0 and rd_busy = 0 while reset is asserted.
- Write priority:
  - A write with address 0 is discarded.
  - If we0 and we1 target the same nonzero address, port 1 wins and only port 1 is traced.
- Read, per port i:
  - Address 0 returns 0.
  - Otherwise, if we1 matches, return wd1; else if we0 matches, return wd0; else return the stored value.
- Scoreboard:
  - pending[a] is cleared at the edge where a write to a commits.
  - pending[a] is set at the edge where iss_valid with iss_addr = a is presented.
  - If set and clear hit the same register in one cycle, set wins; a newer producer is in flight.
  - iss_addr = 0 never sets a pending bit.
- rd_busy[i] = pending[rd_addr_i] AND no enabled write to rd_addr_i this cycle AND rd_addr_i != 0.
- Trace: when TRACE = 1, each committed write prints "time@pc: $reg <= data". pc = wpc − 4, reg in decimal, data in hex. Writes to register 0 are also printed, matching the course grader format.

## Timing
- Reads are fully combinational from rd_addr, we*/wa*/wd*, and state. Zero latency.
- Writes commit on the rising clk edge and are visible from storage in the following cycle. They are visible in the same cycle through bypass.
- Pending bits update on the rising edge. rd_busy reflects the updated state in the cycle after issue.
- Reset deassertion mid-stream: the first edge after deassertion is a normal edge.

## Structure
- grf_pkg holds:
  - default DATA_W and NREG
  - the AW derivation function
  - the trace format string constant
- Natural sub-module: grf_scoreboard. It owns the pending vector, the set/clear priority and the rd_busy generation. Storage, priority and bypass stay in grf_multiport.

## Test plan
- Reset, then read ports 0/1 at addresses 5/31 -> rd_data 0/0, rd_busy 0/0.
- we0 wa0=8 wd0=0x12345678, rd_addr0=8 in the same cycle -> rd_data0 = 0x12345678 via bypass. The next cycle reads the same value from storage.
- we0/we1 both to address 3, wd0=0xAAAA, wd1=0x5555 -> stored and bypassed value 0x5555, one trace line.
- Write 0xFFFFFFFF to address 0 -> reads of address 0 return 0. Trace line printed.
- iss_valid iss_addr=9, then read address 9 -> rd_busy=1. The cycle with we1 wa1=9 gives rd_busy=0 with bypassed data. After that edge, pending[9]=0.
- In one cycle, iss_valid iss_addr=4 and we0 wa0=4 -> pending[4]=1 after the edge. Assert reset asynchronously mid-cycle -> all rd_data and rd_busy go to 0 immediately.
